pa_f_spsram_init: RTL and testbench

- Parametrised single-port synchronous SRAM for FPGA builds: configurable depth and width, per-bit write mask, and a hardware initialisation engine that fills the whole array with a constant after reset or on request.
- Optional output pipeline register.
- Used for core-local tables (BHT, tag, valid arrays) that need a known state without software scrubbing.

---
 rtl/pa_f_spsram_init.sv | 208 ++++++++++++++++++++
 tb/tb_pa_f_spsram_init.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pa_f_spsram_init.sv
// ---------------------------------------------------------------------------
// pa_f_spsram_init
//
// Single-port synchronous SRAM with a built-in initialisation engine. After
// reset, or on request, every entry is filled with INIT_VALUE (one entry per
// cycle). Accesses are only accepted once initialisation has completed.
// Accesses issued before that are discarded and flagged on ACC_DROP.
//
// Parameters:
//   ADDR_WIDTH  address bits, DEPTH = 2**ADDR_WIDTH entries
//   DATA_WIDTH  bits per entry
//   INIT_VALUE  constant written to every entry during initialisation
//   OUT_REG     0: read latency 1, otherwise: extra output register (latency 2)
//
// Ports:
//   CLK        clock, all state on the rising edge
//   cpurst_b   asynchronous active-low reset
//   A          access address
//   CEN        chip enable, active low
//   GWEN       global write enable, active low (0 = write, 1 = read)
//   WEN        per-bit write enable, active low
//   D          write data
//   Q          read data
//   INIT_REQ   single-cycle request to re-run initialisation (READY only)
//   INIT_BUSY  initialisation in progress
//   INIT_DONE  array initialised, ready for access
//   ACC_DROP   one-cycle pulse: an access was issued while not ready
// ---------------------------------------------------------------------------
module pa_f_spsram_init #(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  parameter int                    OUT_REG    = 0
) (
  input  logic                  CLK,
  input  logic                  cpurst_b,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic                  CEN,
  input  logic                  GWEN,
  input  logic [DATA_WIDTH-1:0] WEN,
  input  logic [DATA_WIDTH-1:0] D,
  output logic [DATA_WIDTH-1:0] Q,
  input  logic                  INIT_REQ,
  output logic                  INIT_BUSY,
  output logic                  INIT_DONE,
  output logic                  ACC_DROP
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE_RST = 2'd0,
    INIT     = 2'd1,
    READY    = 2'd2
  } state_e;

  state_e                  state;
  state_e                  state_nxt;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic [ADDR_WIDTH-1:0]   cnt_nxt;

  logic                    ready;
  logic                    acc_rd;
  logic                    acc_wr;
  logic                    drop_nxt;

  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_din;
  logic [DATA_WIDTH-1:0]   mem_bmask;   // active-high bit enable

  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DATA_WIDTH-1:0]   q_rd;

  // ------------------------------------------------------------------------
  // Access qualification
  // ------------------------------------------------------------------------
  assign ready    = (state == READY);
  assign acc_rd   = ready && !CEN &&  GWEN;
  assign acc_wr   = ready && !CEN && !GWEN;
  // Any enabled access outside READY is thrown away and reported.
  assign drop_nxt = !CEN && !ready;

  // ------------------------------------------------------------------------
  // Control FSM: state register
  // ------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge CLK or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state    <= IDLE_RST;
      cnt      <= '0;
      ACC_DROP <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      ACC_DROP <= drop_nxt;
    end
  end

  // ------------------------------------------------------------------------
  // Control FSM: next state and init counter
  // ------------------------------------------------------------------------
  // NOTE: every combinational output gets a default first so no path through
  // the case statement leaves a value unassigned (which would infer a latch).
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE_RST: begin
        state_nxt = INIT;
        cnt_nxt   = '0;
      end
      INIT: begin
        // cnt is exactly ADDR_WIDTH wide, so the increment after the last
        // entry wraps back to 0 ready for the next run.
        cnt_nxt = cnt + 1'b1;
        if (&cnt) begin
          state_nxt = READY;
        end
      end
      READY: begin
        // The access in this cycle still completes; init begins next cycle.
        if (INIT_REQ) begin
          state_nxt = INIT;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE_RST;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign INIT_BUSY = (state == INIT);
  assign INIT_DONE = (state == READY);

  // ------------------------------------------------------------------------
  // Write port mux: the init engine owns the port while INIT is active.
  // ------------------------------------------------------------------------
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = A;
    mem_din   = D;
    mem_bmask = ~WEN;
    if (state == INIT) begin
      mem_we    = 1'b1;
      mem_addr  = cnt;
      mem_din   = INIT_VALUE;
      mem_bmask = '1;
    end else if (acc_wr) begin
      mem_we    = 1'b1;
    end
  end

  // ------------------------------------------------------------------------
  // Storage array
  // ------------------------------------------------------------------------
  // NOTE: the array has no reset; a reset term would stop it mapping onto
  // block RAM, and the init engine provides the known state instead.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      for (int i = 0; i < DATA_WIDTH; i++) begin
        if (mem_bmask[i]) begin
          mem[mem_addr][i] <= mem_din[i];
        end
      end
    end
  end

  // Read data register: only a read in READY updates it, so writes, idle
  // cycles and dropped accesses all leave the last read value in place.
  always_ff @(posedge CLK or negedge cpurst_b) begin
    if (!cpurst_b) begin
      q_rd <= '0;
    end else if (acc_rd) begin
      q_rd <= mem[A];
    end
  end

  // ------------------------------------------------------------------------
  // Optional output pipeline
  // ------------------------------------------------------------------------
  if (OUT_REG != 0) begin : g_out_reg
    logic                  rd_vld;
    logic [DATA_WIDTH-1:0] q_pipe;

    // The pipe register only advances one cycle after a read, so it holds
    // along with q_rd whenever the memory is idle.
    always_ff @(posedge CLK or negedge cpurst_b) begin
      if (!cpurst_b) begin
        rd_vld <= 1'b0;
        q_pipe <= '0;
      end else begin
        rd_vld <= acc_rd;
        if (rd_vld) begin
          q_pipe <= q_rd;
        end
      end
    end

    assign Q = q_pipe;
  end else begin : g_no_out_reg
    assign Q = q_rd;
  end

endmodule

// File: tb/tb_pa_f_spsram_init.sv
// ---------------------------------------------------------------------------
// tb_pa_f_spsram_init
//
// Drives two instances (OUT_REG = 0 and OUT_REG = 1) with identical stimulus
// and compares them against a behavioural model: a plain array for contents,
// a phase plus remaining-cycle count for initialisation, and the rule that
// the registered-output instance shows the same data one cycle later.
// ---------------------------------------------------------------------------
module tb_pa_f_spsram_init;

  localparam int              AW    = 4;
  localparam int              DW    = 32;
  localparam int              DEPTH = 16;
  localparam logic [DW-1:0]   IV    = 32'hA5A5A5A5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [AW-1:0]   a;
  logic            cen;
  logic            gwen;
  logic [DW-1:0]   wen;
  logic [DW-1:0]   d;
  logic            init_req;

  logic [DW-1:0]   q0, q1;
  logic            busy0, done0, drop0;
  logic            busy1, done1, drop1;

  always #5 clk = ~clk;

  pa_f_spsram_init #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_VALUE(IV), .OUT_REG(0)
  ) dut0 (
    .CLK(clk), .cpurst_b(rst_n), .A(a), .CEN(cen), .GWEN(gwen), .WEN(wen),
    .D(d), .Q(q0), .INIT_REQ(init_req), .INIT_BUSY(busy0),
    .INIT_DONE(done0), .ACC_DROP(drop0)
  );

  pa_f_spsram_init #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_VALUE(IV), .OUT_REG(1)
  ) dut1 (
    .CLK(clk), .cpurst_b(rst_n), .A(a), .CEN(cen), .GWEN(gwen), .WEN(wen),
    .D(d), .Q(q1), .INIT_REQ(init_req), .INIT_BUSY(busy1),
    .INIT_DONE(done1), .ACC_DROP(drop1)
  );

  // ------------------------------------------------------------------------
  // Behavioural model
  // ------------------------------------------------------------------------
  int            phase;       // 0 = waiting after reset, 1 = initialising, 2 = ready
  int            init_left;   // init cycles still to run
  logic [DW-1:0] mem_m [DEPTH];
  logic [DW-1:0] q0_m, q1_m;
  logic          drop_m;

  int total = 0;
  int bad   = 0;

  function automatic logic [69:0] obs();
    return {q0, q1, busy0, done0, drop0, busy1, done1, drop1};
  endfunction

  function automatic logic [69:0] exp_v();
    logic b, dn;
    b  = (phase == 1);
    dn = (phase == 2);
    return {q0_m, q1_m, b, dn, drop_m, b, dn, drop_m};
  endfunction

  // One clock: apply the pre-edge inputs to the model, settle, return #1
  // after the edge so the caller can sample outputs and drive new inputs.
  task automatic tick();
    logic [DW-1:0] q0_prev;
    @(posedge clk);
    if (rst_n) begin
      q0_prev = q0_m;
      drop_m  = !cen && (phase != 2);
      case (phase)
        0: begin
          phase     = 1;
          init_left = DEPTH;
        end
        1: begin
          init_left--;
          if (init_left == 0) begin
            phase = 2;
            for (int i = 0; i < DEPTH; i++) mem_m[i] = IV;
          end
        end
        default: begin
          if (!cen) begin
            if (!gwen) mem_m[a] = (mem_m[a] & wen) | (d & ~wen);
            else       q0_m = mem_m[a];
          end
          if (init_req) begin
            phase     = 1;
            init_left = DEPTH;
          end
        end
      endcase
      q1_m = q0_prev;
    end
    #1;
  endtask

  task automatic idle_inputs();
    cen      = 1'b1;
    gwen     = 1'b1;
    wen      = '1;
    d        = '0;
    a        = '0;
    init_req = 1'b0;
  endtask

  task automatic model_reset();
    phase  = 0;
    q0_m   = '0;
    q1_m   = '0;
    drop_m = 1'b0;
  endtask

  // ------------------------------------------------------------------------
  // Scenarios
  // ------------------------------------------------------------------------
  task automatic test_reset();
    #2;
    total++;
    if (q0 !== '0 || q1 !== '0) begin
      bad++;
      $display("FAIL reset_q got=%h/%h exp=0", q0, q1);
    end
    total++;
    if ({busy0, done0, drop0, busy1, done1, drop1} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b exp=000000",
               {busy0, done0, drop0, busy1, done1, drop1});
    end
  endtask

  task automatic test_init_sequence();
    int busy_cycles = 0;
    int n = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    while (!done0 && n < 100) begin
      tick();
      n++;
      if (busy0) busy_cycles++;
      total++;
      if (obs() !== exp_v()) begin
        bad++;
        $display("FAIL init_cycle t=%0t got=%h exp=%h", $time, obs(), exp_v());
      end
    end
    total++;
    if (busy_cycles != DEPTH || done0 !== 1'b1) begin
      bad++;
      $display("FAIL init_length got=%0d done=%b exp=%0d done=1", busy_cycles, done0, DEPTH);
    end
  endtask

  task automatic test_read_all();
    for (int i = 0; i < DEPTH; i++) begin
      cen  = 1'b0;
      gwen = 1'b1;
      a    = AW'(i);
      tick();
      total++;
      if (q0 !== IV || obs() !== exp_v()) begin
        bad++;
        $display("FAIL read_init a=%0d got=%h exp=%h", i, q0, IV);
      end
    end
    idle_inputs();
  endtask

  task automatic test_masked_write();
    logic [DW-1:0] q_before;
    q_before = q0;
    cen  = 1'b0;
    gwen = 1'b0;
    a    = 4'd3;
    d    = 32'hFFFFFFFF;
    wen  = 32'hFFFF0000;
    tick();
    total++;
    if (q0 !== q_before || obs() !== exp_v()) begin
      bad++;
      $display("FAIL write_holds_q got=%h exp=%h", q0, q_before);
    end
    gwen = 1'b1;
    wen  = '1;
    tick();
    total++;
    if (q0 !== 32'hA5A5FFFF) begin
      bad++;
      $display("FAIL masked_read got=%h exp=a5a5ffff", q0);
    end
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (q0 !== 32'hA5A5FFFF || obs() !== exp_v()) begin
        bad++;
        $display("FAIL cen_hold i=%0d got=%h exp=a5a5ffff", i, q0);
      end
    end
  endtask

  task automatic test_out_reg_pipeline();
    // Give address 4 a distinct value, then park both outputs on entry 5.
    cen = 1'b0; gwen = 1'b0; a = 4'd4; d = 32'h0BADF00D; wen = '0;
    tick();
    gwen = 1'b1; wen = '1; a = 4'd5;
    tick();
    idle_inputs();
    tick();
    tick();
    total++;
    if (q1 !== IV) begin
      bad++;
      $display("FAIL pipe_prime got=%h exp=%h", q1, IV);
    end
    // Single read of 3: visible on the registered output two edges later.
    cen = 1'b0; gwen = 1'b1; a = 4'd3;
    tick();
    idle_inputs();
    total++;
    if (q1 !== IV || q0 !== 32'hA5A5FFFF) begin
      bad++;
      $display("FAIL pipe_t1 got=%h/%h exp=a5a5ffff/%h", q0, q1, IV);
    end
    tick();
    total++;
    if (q1 !== 32'hA5A5FFFF) begin
      bad++;
      $display("FAIL pipe_t2 got=%h exp=a5a5ffff", q1);
    end
    // Park on 5 again, then back-to-back reads of 3 and 4.
    cen = 1'b0; a = 4'd5;
    tick();
    idle_inputs();
    tick();
    cen = 1'b0; gwen = 1'b1; a = 4'd3;
    tick();
    a = 4'd4;
    tick();
    idle_inputs();
    total++;
    if (q1 !== 32'hA5A5FFFF) begin
      bad++;
      $display("FAIL b2b_first got=%h exp=a5a5ffff", q1);
    end
    tick();
    total++;
    if (q1 !== 32'h0BADF00D || obs() !== exp_v()) begin
      bad++;
      $display("FAIL b2b_second got=%h exp=0badf00d", q1);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      cen      = ($urandom_range(0, 9) < 3);
      gwen     = $urandom_range(0, 1) == 1;
      a        = AW'($urandom_range(0, DEPTH - 1));
      d        = $urandom;
      case ($urandom_range(0, 3))
        0:       wen = '1;
        1:       wen = '0;
        default: wen = $urandom;
      endcase
      init_req = ($urandom_range(0, 59) == 0);
      tick();
      total++;
      if (obs() !== exp_v()) begin
        bad++;
        $display("FAIL random i=%0d got=%h exp=%h", i, obs(), exp_v());
      end
    end
    idle_inputs();
    // Let any init started by the random traffic finish.
    for (int n = 0; n < 40 && phase != 2; n++) tick();
  endtask

  task automatic test_drop_during_init();
    int busy_cycles = 0;
    int drops = 0;
    int n = 0;
    // Request init together with a full write to address 2.
    init_req = 1'b1; cen = 1'b0; gwen = 1'b0; a = 4'd2; d = 32'h12345678; wen = '0;
    tick();
    idle_inputs();
    busy_cycles = busy0 ? 1 : 0;
    while (!done0 && n < 100) begin
      // Init cycle 5: a write that must be discarded.
      if (busy_cycles == 5) begin
        cen = 1'b0; gwen = 1'b0; a = 4'd7; d = 32'hDEADBEEF; wen = '0;
      end else begin
        cen = 1'b1;
      end
      // A second request during init must not stretch it.
      init_req = (busy_cycles == 9);
      tick();
      n++;
      if (busy0) busy_cycles++;
      if (drop0) drops++;
      total++;
      if (obs() !== exp_v()) begin
        bad++;
        $display("FAIL drop_cycle t=%0t got=%h exp=%h", $time, obs(), exp_v());
      end
    end
    idle_inputs();
    total++;
    if (busy_cycles != DEPTH || drops != 1) begin
      bad++;
      $display("FAIL drop_init busy=%0d drops=%0d exp busy=%0d drops=1", busy_cycles, drops, DEPTH);
    end
    cen = 1'b0; gwen = 1'b1; a = 4'd7;
    tick();
    a = 4'd2;
    total++;
    if (q0 !== IV) begin
      bad++;
      $display("FAIL dropped_addr got=%h exp=%h", q0, IV);
    end
    tick();
    idle_inputs();
    total++;
    if (q0 !== IV) begin
      bad++;
      $display("FAIL reinit_addr2 got=%h exp=%h", q0, IV);
    end
  endtask

  task automatic test_reset_mid_init();
    int busy_cycles = 0;
    int n = 0;
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (obs() !== exp_v()) begin
      bad++;
      $display("FAIL async_reset got=%h exp=%h", obs(), exp_v());
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (busy0 !== 1'b0 || done0 !== 1'b0 || obs() !== exp_v()) begin
        bad++;
        $display("FAIL held_reset busy=%b done=%b exp 0/0", busy0, done0);
      end
    end
    rst_n = 1'b1;
    while (!done0 && n < 100) begin
      tick();
      n++;
      if (busy0) busy_cycles++;
      total++;
      if (obs() !== exp_v()) begin
        bad++;
        $display("FAIL reinit_cycle t=%0t got=%h exp=%h", $time, obs(), exp_v());
      end
    end
    total++;
    if (busy_cycles != DEPTH || done0 !== 1'b1) begin
      bad++;
      $display("FAIL reinit_length got=%0d done=%b exp=%0d done=1", busy_cycles, done0, DEPTH);
    end
    for (int i = 0; i < DEPTH; i += 5) begin
      cen = 1'b0; gwen = 1'b1; a = AW'(i);
      tick();
      total++;
      if (q0 !== IV) begin
        bad++;
        $display("FAIL post_reset_read a=%0d got=%h exp=%h", i, q0, IV);
      end
    end
    idle_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    test_reset();
    test_init_sequence();
    test_read_all();
    test_masked_write();
    test_out_reg_pipeline();
    test_random();
    test_drop_during_init();
    test_reset_mid_init();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
